down_counter_163: RTL and testbench

- Synchronous presettable binary down counter; the decrementing counterpart of the team's 74163-style up counter. Mirrors its CLR_L/LD_L/ENT/ENP control set.
- Adds a borrow output for cascading and an auto-reload mode, so it can serve as a programmable divide-by-(N+1) timer.
- Sits beside the up counter in the discrete-logic library and feeds tick/strobe generation in downstream projects.

---
 rtl/down_counter_pkg.sv | 21 ++
 rtl/down_counter_next.sv | 63 ++++++
 rtl/down_counter_163.sv | 52 +++++
 tb/tb_down_counter_163.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/down_counter_pkg.sv
// Shared definitions for the presettable down counter: default width and the
// next-action code shared by the next-state selector and its bench model.
package down_counter_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MIN_WIDTH     = 2;
    localparam int MAX_WIDTH     = 16;

    localparam logic [DEFAULT_WIDTH-1:0] DEF_CNT_ZERO = '0;
    localparam logic [DEFAULT_WIDTH-1:0] DEF_CNT_ONES = '1;

    typedef enum logic [2:0] {
        ACT_CLEAR  = 3'd0,
        ACT_LOAD   = 3'd1,
        ACT_DEC    = 3'd2,
        ACT_RELOAD = 3'd3,
        ACT_WRAP   = 3'd4,
        ACT_HOLD   = 3'd5
    } next_action_e;

endpackage

// File: rtl/down_counter_next.sv
// Combinational next-state selector: classifies the edge into one action, then
// derives next count and next reload flag. Honours DOWN_CNT_HOLD_AT_ZERO_EN.
module down_counter_next
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clr_l,
    input  logic             ld_l,
    input  logic             ent,
    input  logic             enp,
    input  logic             auto_ld,
    input  logic [WIDTH-1:0] din,
    input  logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_next,
    output logic             rld_next
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [WIDTH-1:0] CNT_ONES = '1;
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    next_action_e act;

    // Priority: clear, load, then counting; enables never gate clear or load.
    always_comb begin
        act = ACT_HOLD;
        if (!clr_l) begin
            act = ACT_CLEAR;
        end else if (!ld_l) begin
            act = ACT_LOAD;
        end else if (ent && enp) begin
            if (q != CNT_ZERO) begin
                act = ACT_DEC;
            end else if (auto_ld) begin
                act = ACT_RELOAD;
            end else begin
`ifdef DOWN_CNT_HOLD_AT_ZERO_EN
                act = ACT_HOLD;
`else
                act = ACT_WRAP;
`endif
            end
        end
    end

    always_comb begin
        q_next   = q;
        rld_next = 1'b0;
        case (act)
            ACT_CLEAR:  q_next = CNT_ZERO;
            ACT_LOAD:   q_next = din;
            ACT_DEC:    q_next = q - CNT_ONE;
            ACT_RELOAD: begin
                q_next   = din;
                rld_next = 1'b1;
            end
            ACT_WRAP:   q_next = CNT_ONES;
            default:    q_next = q;
        endcase
    end

endmodule

// File: rtl/down_counter_163.sv
// Synchronous presettable down counter with borrow-out cascading and optional
// auto-reload; DOWN_CNT_HOLD_AT_ZERO_EN makes non-reload underflow saturate at 0.
module down_counter_163
    import down_counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             CLK,
    input  logic             CLR_L,
    input  logic             LD_L,
    input  logic             ENT,
    input  logic             ENP,
    input  logic             AUTO_LD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             ZERO,
    output logic             RLD
);

    localparam logic [WIDTH-1:0] CNT_ZERO = '0;

    logic [WIDTH-1:0] q_next;
    logic             rld_next;

    down_counter_next #(.WIDTH(WIDTH)) u_next (
        .clr_l    (CLR_L),
        .ld_l     (LD_L),
        .ent      (ENT),
        .enp      (ENP),
        .auto_ld  (AUTO_LD),
        .din      (DIN),
        .q        (Q),
        .q_next   (q_next),
        .rld_next (rld_next)
    );

    always_ff @(posedge CLK) begin
        if (!CLR_L) begin
            Q   <= CNT_ZERO;
            RLD <= 1'b0;
        end else begin
            Q   <= q_next;
            RLD <= rld_next;
        end
    end

    // ENT gates the borrow so a cascaded stage only sees it when its feeder counts.
    assign ZERO = (Q == CNT_ZERO);
    assign BO   = ENT & ZERO;

endmodule

// File: tb/tb_down_counter_163.sv
// Bench for down_counter_163: directed scenarios plus randomized runs against a
// behavioural model, for a single 4-bit counter and an 8-bit two-stage cascade.
module tb_down_counter_163;
    import down_counter_pkg::*;

    localparam int W = 4;

`ifdef DOWN_CNT_HOLD_AT_ZERO_EN
    localparam logic [W-1:0] UNDER_1 = 4'd0;
    localparam logic [W-1:0] UNDER_2 = 4'd0;
    localparam logic [7:0]   CASC_1  = 8'h00;
    localparam logic [7:0]   CASC_2  = 8'h00;
`else
    localparam logic [W-1:0] UNDER_1 = 4'd15;
    localparam logic [W-1:0] UNDER_2 = 4'd14;
    localparam logic [7:0]   CASC_1  = 8'h0F;
    localparam logic [7:0]   CASC_2  = 8'h0E;
`endif

    // clock
    logic clk = 1'b0;
    always #5 clk = ~clk;

    // single counter
    logic         clr_l, ld_l, ent, enp, auto_ld;
    logic [W-1:0] din, q;
    logic         bo, zero, rld;

    down_counter_163 #(.WIDTH(W)) dut (
        .CLK(clk), .CLR_L(clr_l), .LD_L(ld_l), .ENT(ent), .ENP(enp),
        .AUTO_LD(auto_ld), .DIN(din), .Q(q), .BO(bo), .ZERO(zero), .RLD(rld)
    );

    // two-stage cascade
    logic       c_clr_l, c_ld_l, c_ent, c_enp;
    logic [7:0] c_din, c_q;
    logic       c_bo_lo, c_bo_hi, c_zero_lo, c_zero_hi, c_rld_lo, c_rld_hi;

    down_counter_163 #(.WIDTH(W)) dut_lo (
        .CLK(clk), .CLR_L(c_clr_l), .LD_L(c_ld_l), .ENT(c_ent), .ENP(c_enp),
        .AUTO_LD(1'b0), .DIN(c_din[3:0]), .Q(c_q[3:0]), .BO(c_bo_lo),
        .ZERO(c_zero_lo), .RLD(c_rld_lo)
    );

    down_counter_163 #(.WIDTH(W)) dut_hi (
        .CLK(clk), .CLR_L(c_clr_l), .LD_L(c_ld_l), .ENT(c_bo_lo), .ENP(c_enp),
        .AUTO_LD(1'b0), .DIN(c_din[7:4]), .Q(c_q[7:4]), .BO(c_bo_hi),
        .ZERO(c_zero_hi), .RLD(c_rld_hi)
    );

    int chk_cnt  = 0;
    int pass_cnt = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_rld_q[$];
    logic [7:0]   exp_c_q[$];

    // reference model: single counter, result is {rld, q}
    function automatic logic [W:0] ref_next(input logic [W-1:0] cur, input logic c,
                                            input logic l, input logic t, input logic p,
                                            input logic a, input logic [W-1:0] d);
        next_action_e act;
        int           nq;
        logic         r;
        r  = 1'b0;
        nq = int'(cur);
        if (!c)                act = ACT_CLEAR;
        else if (!l)           act = ACT_LOAD;
        else if (!(t && p))    act = ACT_HOLD;
        else if (cur != 0)     act = ACT_DEC;
        else if (a)            act = ACT_RELOAD;
`ifdef DOWN_CNT_HOLD_AT_ZERO_EN
        else                   act = ACT_HOLD;
`else
        else                   act = ACT_WRAP;
`endif
        case (act)
            ACT_CLEAR:  nq = 0;
            ACT_LOAD:   nq = int'(d);
            ACT_DEC:    nq = (int'(cur) - 1 + (1 << W)) % (1 << W);
            ACT_RELOAD: begin nq = int'(d); r = 1'b1; end
            ACT_WRAP:   nq = (1 << W) - 1;
            default:    nq = int'(cur);
        endcase
        return {r, W'(nq)};
    endfunction

    // reference model: 8-bit value formed by two cascaded stages
    function automatic logic [7:0] ref_casc(input logic [7:0] v, input logic c,
                                            input logic l, input logic t, input logic p,
                                            input logic [7:0] d);
        int lo, hi;
        if (!c) return 8'h00;
        if (!l) return d;
        if (!(t && p)) return v;
        lo = int'(v[3:0]);
        hi = int'(v[7:4]);
        if (lo != 0) return v - 8'd1;
`ifdef DOWN_CNT_HOLD_AT_ZERO_EN
        hi = (hi == 0) ? 0 : hi - 1;
        return 8'(hi * 16);
`else
        return v - 8'd1;
`endif
    endfunction

    task automatic drive(input logic c, input logic l, input logic t, input logic p,
                         input logic a, input logic [W-1:0] d);
        clr_l = c; ld_l = l; ent = t; enp = p; auto_ld = a; din = d;
    endtask

    task automatic cdrive(input logic c, input logic l, input logic t, input logic p,
                          input logic [7:0] d);
        c_clr_l = c; c_ld_l = l; c_ent = t; c_enp = p; c_din = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 4'd9); tick();
        drive(0, 0, 1, 0, 0, 4'd9); tick();
        chk_cnt++; if (q !== 4'd0) $display("FAIL reset_q: got %0d exp 0", q); else pass_cnt++;
        chk_cnt++; if (rld !== 1'b0) $display("FAIL reset_rld: got %b exp 0", rld); else pass_cnt++;
        chk_cnt++; if (zero !== 1'b1) $display("FAIL reset_zero: got %b exp 1", zero); else pass_cnt++;
        chk_cnt++; if (bo !== 1'b1) $display("FAIL reset_bo_ent1: got %b exp 1", bo); else pass_cnt++;
        drive(1, 0, 0, 0, 0, 4'd9); tick();
        drive(0, 0, 0, 0, 0, 4'd5); tick();
        chk_cnt++; if (q !== 4'd0) $display("FAIL clear_wins_q: got %0d exp 0", q); else pass_cnt++;
        chk_cnt++; if (bo !== 1'b0) $display("FAIL reset_bo_ent0: got %b exp 0", bo); else pass_cnt++;
    endtask

    task automatic test_load_count();
        logic [W-1:0] seq [5];
        seq[0] = 4'd2; seq[1] = 4'd1; seq[2] = 4'd0; seq[3] = UNDER_1; seq[4] = UNDER_2;
        drive(1, 0, 0, 0, 0, 4'd3); tick();
        chk_cnt++; if (q !== 4'd3) $display("FAIL load_q: got %0d exp 3", q); else pass_cnt++;
        drive(1, 1, 1, 1, 0, 4'd3);
        #1;
        chk_cnt++; if (bo !== 1'b0) $display("FAIL load_bo: got %b exp 0", bo); else pass_cnt++;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_cnt++;
            if (q !== seq[i]) $display("FAIL count_q[%0d]: got %0d exp %0d", i, q, seq[i]);
            else pass_cnt++;
            chk_cnt++;
            if (bo !== (seq[i] == 4'd0)) $display("FAIL count_bo[%0d]: got %b exp %b", i, bo, seq[i] == 4'd0);
            else pass_cnt++;
        end
    endtask

    task automatic test_auto_reload();
        logic [W-1:0] e;
        drive(1, 0, 0, 0, 1, 4'd2); tick();
        drive(1, 1, 1, 1, 1, 4'd2);
        for (int i = 0; i < 9; i++) begin
            tick();
            e = (i % 3 == 0) ? 4'd1 : (i % 3 == 1) ? 4'd0 : 4'd2;
            chk_cnt++;
            if (q !== e) $display("FAIL reload_q[%0d]: got %0d exp %0d", i, q, e); else pass_cnt++;
            chk_cnt++;
            if (rld !== (i % 3 == 2)) $display("FAIL reload_rld[%0d]: got %b exp %b", i, rld, i % 3 == 2);
            else pass_cnt++;
            // DIN is ignored on a plain decrement edge
            din = (i % 3 == 0) ? 4'd9 : 4'd2;
        end
        drive(1, 0, 0, 0, 1, 4'd0); tick();
        drive(1, 1, 1, 1, 1, 4'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (q !== 4'd0 || rld !== 1'b1) $display("FAIL div1[%0d]: got q=%0d rld=%b exp q=0 rld=1", i, q, rld);
            else pass_cnt++;
        end
    endtask

    task automatic test_enable_gating();
        drive(1, 0, 0, 0, 0, 4'd0); tick();
        drive(1, 1, 1, 0, 0, 4'd7); tick();
        chk_cnt++; if (q !== 4'd0 || bo !== 1'b1) $display("FAIL gate_enp0: got q=%0d bo=%b exp q=0 bo=1", q, bo); else pass_cnt++;
        drive(1, 1, 0, 1, 0, 4'd7); tick();
        chk_cnt++; if (q !== 4'd0 || bo !== 1'b0 || zero !== 1'b1) $display("FAIL gate_ent0: got q=%0d bo=%b zero=%b exp 0 0 1", q, bo, zero); else pass_cnt++;
        drive(1, 0, 0, 0, 0, 4'd5); tick();
        drive(1, 1, 1, 0, 0, 4'd5); tick();
        drive(1, 1, 0, 1, 0, 4'd5); tick();
        chk_cnt++; if (q !== 4'd5) $display("FAIL gate_hold5: got %0d exp 5", q); else pass_cnt++;
        drive(1, 0, 0, 0, 0, 4'd6); tick();
        chk_cnt++; if (q !== 4'd6) $display("FAIL load_no_enable: got %0d exp 6", q); else pass_cnt++;
    endtask

    task automatic test_hold_at_zero();
        logic [W-1:0] seq [3];
        seq[0] = 4'd0; seq[1] = UNDER_1; seq[2] = UNDER_2;
        drive(1, 0, 0, 0, 0, 4'd1); tick();
        drive(1, 1, 1, 1, 0, 4'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_cnt++;
            if (q !== seq[i] || bo !== (seq[i] == 4'd0) || rld !== 1'b0)
                $display("FAIL underflow[%0d]: got q=%0d bo=%b rld=%b exp q=%0d bo=%b rld=0",
                         i, q, bo, rld, seq[i], seq[i] == 4'd0);
            else pass_cnt++;
        end
    endtask

    task automatic test_cascade();
        cdrive(1, 0, 0, 0, 8'h10); tick();
        chk_cnt++; if (c_q !== 8'h10) $display("FAIL casc_load: got %h exp 10", c_q); else pass_cnt++;
        cdrive(1, 1, 1, 1, 8'h10); tick();
        chk_cnt++; if (c_q !== CASC_1) $display("FAIL casc_step1: got %h exp %h", c_q, CASC_1); else pass_cnt++;
        tick();
        chk_cnt++; if (c_q !== CASC_2) $display("FAIL casc_step2: got %h exp %h", c_q, CASC_2); else pass_cnt++;
    endtask

    task automatic test_random();
        logic [W-1:0] m_q, e;
        logic         m_rld, er;
        logic [W:0]   nx;
        m_q = '0; m_rld = 1'b0;
        for (int i = 0; i < 400; i++) begin
            drive((i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0), $urandom_range(0, 7) != 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            nx = ref_next(m_q, clr_l, ld_l, ent, enp, auto_ld, din);
            m_q = nx[W-1:0]; m_rld = nx[W];
            exp_q.push_back(m_q); exp_rld_q.push_back(m_rld);
            tick();
            e = exp_q.pop_front(); er = exp_rld_q.pop_front();
            chk_cnt++;
            if (q !== e || rld !== er || zero !== (e == 0) || bo !== (ent && e == 0))
                $display("FAIL rand[%0d]: got q=%0d rld=%b zero=%b bo=%b exp q=%0d rld=%b", i, q, rld, zero, bo, e, er);
            else pass_cnt++;
        end
    endtask

    task automatic test_cascade_random();
        logic [7:0] v, e;
        v = 8'h00;
        for (int i = 0; i < 300; i++) begin
            cdrive((i == 0) ? 1'b0 : ($urandom_range(0, 31) != 0), $urandom_range(0, 15) != 0,
                   $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                   8'(($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) * 16 : $urandom_range(0, 255)));
            v = ref_casc(v, c_clr_l, c_ld_l, c_ent, c_enp, c_din);
            exp_c_q.push_back(v);
            tick();
            e = exp_c_q.pop_front();
            chk_cnt++;
            if (c_q !== e || c_bo_hi !== (c_ent && e == 8'h00) || (c_zero_lo && c_zero_hi) !== (e == 8'h00)
                || c_rld_lo !== 1'b0 || c_rld_hi !== 1'b0)
                $display("FAIL casc_rand[%0d]: got %h bo=%b exp %h bo=%b", i, c_q, c_bo_hi, e, c_ent && e == 8'h00);
            else pass_cnt++;
        end
    endtask

    initial begin
        drive(0, 1, 0, 0, 0, 4'd0);
        cdrive(0, 1, 0, 0, 8'h00);
        tick();
        test_reset();
        test_load_count();
        test_auto_reload();
        test_enable_gating();
        test_hold_at_zero();
        test_cascade();
        test_random();
        test_cascade_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
